// File: rtl/stream_max_log_llr_pkg.sv
// rtl/stream_max_log_llr_pkg.sv - shared helpers and types for the max-log LLR stream
// Purpose: clog2 helper, LLR saturation, metric/LLR typedefs, pipeline latency
// calculation and the candidate-index helper used by the top level.
package stream_max_log_llr_pkg;

  localparam int DEF_BITS     = 16;
  localparam int DEF_LLR_BITS = 16;

  typedef logic signed [DEF_BITS-1:0]     metric_t;
  typedef logic signed [DEF_BITS+1:0]     cand_t;
  typedef logic signed [DEF_LLR_BITS-1:0] llr_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Candidate register + one register per max-tree level + subtract/saturate register.
  function automatic int lat_calc(input int states, input int input_symbols);
    return 2 + clog2(states * input_symbols / 2);
  endfunction

  // Maps the idx-th input symbol whose bit k equals b back to the full input symbol u.
  function automatic int insert_bit(input int idx, input int k, input int b);
    return ((idx >> k) << (k + 1)) | (b << k) | (idx & ((1 << k) - 1));
  endfunction

  function automatic logic signed [63:0] saturate(input logic signed [63:0] x, input int width);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/stream_max_log_llr_if.sv
// rtl/stream_max_log_llr_if.sv - trellis table interface
// Purpose: carries the trellis description into the LLR block.
// Signals: next_state[s][u] successor state, outputs[s][u] output symbol index.
// Modports: master drives the tables, slave reads them.
interface trellis_if import stream_max_log_llr_pkg::*; #(
  parameter int STATES         = 4,
  parameter int INPUT_SYMBOLS  = 4,
  parameter int OUTPUT_SYMBOLS = 4
) ();
  localparam int SW = (STATES > 1) ? clog2(STATES) : 1;
  localparam int OW = (OUTPUT_SYMBOLS > 1) ? clog2(OUTPUT_SYMBOLS) : 1;

  logic [SW-1:0] next_state [STATES][INPUT_SYMBOLS];
  logic [OW-1:0] outputs    [STATES][INPUT_SYMBOLS];

  modport master (output next_state, outputs);
  modport slave  (input  next_state, outputs);
endinterface

// File: rtl/stream_max_log_llr_max_tree.sv
// rtl/stream_max_log_llr_max_tree.sv - pipelined signed binary max tree
// Purpose: maximum of WIDTH signed values, one register per tree level.
// Ports: clk clock; en advances all levels; din WIDTH x BITS operands;
//        max_out registered maximum (clog2(WIDTH) cycles after din).
module max_tree_pipe import stream_max_log_llr_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int BITS  = 18
) (
  input  logic                       clk,
  input  logic                       en,
  input  logic [WIDTH-1:0][BITS-1:0] din,
  output logic [BITS-1:0]            max_out
);
  localparam int LEVELS = clog2(WIDTH);
  localparam int P      = 1 << LEVELS;
  // Padding leaves use the most negative value so they never win.
  localparam logic [BITS-1:0] MIN_VAL = {1'b1, {(BITS-1){1'b0}}};

  // Heap layout: full[1] is the root, full[P..2P-1] are the leaves.
  logic [BITS-1:0] full [1:2*P-1];
  logic [BITS-1:0] node [1:P-1];

  function automatic logic [BITS-1:0] smax(input logic [BITS-1:0] a, input logic [BITS-1:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

  for (genvar g = 1; g < 2 * P; g++) begin : g_full
    if (g < P) begin : g_node
      assign full[g] = node[g];
    end else if (g - P < WIDTH) begin : g_leaf
      assign full[g] = din[g-P];
    end else begin : g_pad
      assign full[g] = MIN_VAL;
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 1; i < P; i++) node[i] <= smax(full[2*i], full[2*i+1]);
    end
  end

  assign max_out = full[1];
endmodule

// File: rtl/stream_max_log_llr.sv
// rtl/stream_max_log_llr.sv - streaming max-log LLR computation
// Purpose: per-bit max-log LLR from alpha, beta and branch metrics over a trellis.
// Ports: clk, rst (async active-high); trellis tables (trellis_if.slave);
//        in_valid/in_ready input handshake; branch_metric, AlphaMetric,
//        BetaMetric, apriori beat data; out_valid/out_ready output handshake;
//        LLR_D per-bit saturated LLR; out_last marks symbol SYMBOLS-1.
module stream_max_log_llr import stream_max_log_llr_pkg::*; #(
  parameter int BITS            = 16,
  parameter int LLR_BITS        = 16,
  parameter int BITS_PER_SYMBOL = 2,
  parameter int STATES          = 4,
  parameter int OUTPUT_SYMBOLS  = 4,
  parameter int SYMBOLS         = 10,
  parameter int EXTRINSIC       = 0
) (
  input  logic                                     clk,
  input  logic                                     rst,
  trellis_if.slave                                 trellis,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic [OUTPUT_SYMBOLS-1:0][BITS-1:0]      branch_metric,
  input  logic [STATES-1:0][BITS-1:0]              AlphaMetric,
  input  logic [STATES-1:0][BITS-1:0]              BetaMetric,
  input  logic [BITS_PER_SYMBOL-1:0][BITS-1:0]     apriori,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [BITS_PER_SYMBOL-1:0][LLR_BITS-1:0] LLR_D,
  output logic                                     out_last
);
  localparam int INPUT_SYMBOLS = 2 ** BITS_PER_SYMBOL;
  localparam int HALF          = INPUT_SYMBOLS / 2;
  localparam int CAND          = STATES * HALF;
  localparam int LAT           = lat_calc(STATES, INPUT_SYMBOLS);
  localparam int LEVELS        = LAT - 2;
  localparam int CW            = BITS + 2;  // alpha + gamma + beta never overflows
  localparam int DW            = BITS + 4;  // difference minus a-priori never overflows
  localparam int CNT_W         = (SYMBOLS > 1) ? clog2(SYMBOLS) : 1;

  logic en, accept, at_last;
  logic [CNT_W-1:0] sym_cnt;
  logic [LEVELS:0]  v_q, last_q;
  logic [BITS_PER_SYMBOL-1:0][BITS-1:0] ap_q [LEVELS+1];

  // cand_q[k][b] holds the CAND candidates whose input symbol has bit k == b.
  logic [CAND-1:0][CW-1:0] cand_q [BITS_PER_SYMBOL][2];
  logic [CW-1:0]           m_q    [BITS_PER_SYMBOL][2];

  logic signed [DW-1:0]                     diff_c [BITS_PER_SYMBOL];
  logic [BITS_PER_SYMBOL-1:0][LLR_BITS-1:0] llr_c;

  // The whole pipeline freezes while the output beat is stalled.
  assign in_ready = !(out_valid && !out_ready);
  assign en       = in_ready;
  assign accept   = in_valid && in_ready;
  assign at_last  = (sym_cnt == CNT_W'(SYMBOLS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sym_cnt   <= '0;
      v_q       <= '0;
      last_q    <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      LLR_D     <= '0;
    end else if (en) begin
      if (accept) sym_cnt <= at_last ? '0 : sym_cnt + 1'b1;
      v_q       <= {v_q[LEVELS-1:0], accept};
      last_q    <= {last_q[LEVELS-1:0], accept && at_last};
      out_valid <= v_q[LEVELS];
      out_last  <= last_q[LEVELS];
      LLR_D     <= llr_c;
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      ap_q[0] <= apriori;
      for (int i = 1; i <= LEVELS; i++) ap_q[i] <= ap_q[i-1];
      for (int k = 0; k < BITS_PER_SYMBOL; k++)
        for (int b = 0; b < 2; b++)
          for (int s = 0; s < STATES; s++)
            for (int i = 0; i < HALF; i++)
              cand_q[k][b][s*HALF+i] <=
                  CW'($signed(AlphaMetric[s]))
                + CW'($signed(branch_metric[trellis.outputs[s][insert_bit(i, k, b)]]))
                + CW'($signed(BetaMetric[trellis.next_state[s][insert_bit(i, k, b)]]));
    end
  end

  for (genvar gk = 0; gk < BITS_PER_SYMBOL; gk++) begin : g_bit
    for (genvar gb = 0; gb < 2; gb++) begin : g_val
      max_tree_pipe #(.WIDTH(CAND), .BITS(CW)) u_tree (
        .clk     (clk),
        .en      (en),
        .din     (cand_q[gk][gb]),
        .max_out (m_q[gk][gb])
      );
    end
  end

  always_comb begin
    for (int k = 0; k < BITS_PER_SYMBOL; k++) begin
      diff_c[k] = DW'($signed(m_q[k][1])) - DW'($signed(m_q[k][0]));
      if (EXTRINSIC != 0) diff_c[k] = diff_c[k] - DW'($signed(ap_q[LEVELS][k]));
      llr_c[k] = LLR_BITS'(saturate(64'(diff_c[k]), LLR_BITS));
    end
  end
endmodule
